// File: rtl/fp32_add_post.sv
// Result stage of the single-precision adder: IEEE special-case and range fixup behind a
// 2-stage valid/ready pipeline with sticky fflags. Optional event counter: FP32_ADD_POST_EXC_CNT_EN.
module fp32_add_post #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [31:0]      in_raw_r,
    input  logic [9:0]       in_raw_exp,
    input  logic             in_raw_zero,
    input  logic             in_inexact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [4:0]       out_flags,
    output logic [4:0]       fflags,
`ifdef FP32_ADD_POST_EXC_CNT_EN
    output logic [CNT_W-1:0] exc_count,
`endif
    input  logic             fflags_clr
);

    // Valid/ready: a beat moves when valid & ready are both high on a rising edge; a
    // producer holding valid keeps its payload stable until that edge, and stage 1 only
    // refills when its current beat moves on to stage 2 (or stage 1 is empty).

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
    } cls_t;

    function automatic cls_t classify(input logic [31:0] v);
        cls_t c;
        c.nan  = (&v[30:23]) & (|v[22:0]);
        c.snan = c.nan & ~v[22];
        c.inf  = (&v[30:23]) & ~(|v[22:0]);
        c.zero = ~(|v[30:23]);
        return c;
    endfunction

    localparam logic [4:0] FLAG_NV = 5'b10000;
    localparam logic [4:0] FLAG_OF = 5'b00100;
    localparam logic [4:0] FLAG_UF = 5'b00010;
    localparam logic [4:0] FLAG_NX = 5'b00001;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_x_q, s1_x_d;
    logic [31:0] s1_y_q, s1_y_d;
    logic [31:0] s1_raw_r_q, s1_raw_r_d;
    logic [9:0]  s1_raw_exp_q, s1_raw_exp_d;
    logic        s1_raw_zero_q, s1_raw_zero_d;
    logic        s1_inexact_q, s1_inexact_d;
    cls_t        s1_cx_q, s1_cx_d;
    cls_t        s1_cy_q, s1_cy_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_r_q, out_r_d;
    logic [4:0]  out_flags_q, out_flags_d;
    logic [4:0]  fflags_q, fflags_d;

    logic        s2_adv;
    logic        out_xfer;
    logic [31:0] sel_r;
    logic [4:0]  sel_flags;

    assign s2_adv    = ~out_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_adv;
    assign out_xfer  = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_flags = out_flags_q;
    assign fflags    = fflags_q;

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_x_d        = s1_x_q;
        s1_y_d        = s1_y_q;
        s1_raw_r_d    = s1_raw_r_q;
        s1_raw_exp_d  = s1_raw_exp_q;
        s1_raw_zero_d = s1_raw_zero_q;
        s1_inexact_d  = s1_inexact_q;
        s1_cx_d       = s1_cx_q;
        s1_cy_d       = s1_cy_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d        = in_x;
                s1_y_d        = in_y;
                s1_raw_r_d    = in_raw_r;
                s1_raw_exp_d  = in_raw_exp;
                s1_raw_zero_d = in_raw_zero;
                s1_inexact_d  = in_inexact;
                s1_cx_d       = classify(in_x);
                s1_cy_d       = classify(in_y);
            end
        end
    end

    // Priority order matters: NaN beats infinity, which beats any zero or range fixup.
    always_comb begin
        sel_r     = s1_raw_r_q;
        sel_flags = s1_inexact_q ? FLAG_NX : 5'b0;
        if (s1_cx_q.nan | s1_cy_q.nan) begin
            sel_r     = CANON_NAN;
            sel_flags = (s1_cx_q.snan | s1_cy_q.snan) ? FLAG_NV : 5'b0;
        end else if (s1_cx_q.inf & s1_cy_q.inf & (s1_x_q[31] ^ s1_y_q[31])) begin
            sel_r     = CANON_NAN;
            sel_flags = FLAG_NV;
        end else if (s1_cx_q.inf) begin
            sel_r     = {s1_x_q[31], 8'hFF, 23'b0};
            sel_flags = 5'b0;
        end else if (s1_cy_q.inf) begin
            sel_r     = {s1_y_q[31], 8'hFF, 23'b0};
            sel_flags = 5'b0;
        end else if (s1_cx_q.zero & s1_cy_q.zero) begin
            sel_r     = {s1_x_q[31] & s1_y_q[31], 31'b0};
            sel_flags = 5'b0;
        end else if (s1_cx_q.zero) begin
            sel_r     = s1_y_q;
            sel_flags = 5'b0;
        end else if (s1_cy_q.zero) begin
            sel_r     = s1_x_q;
            sel_flags = 5'b0;
        end else if (s1_raw_zero_q) begin
            sel_r     = 32'b0;
            sel_flags = 5'b0;
        end else if ($signed(s1_raw_exp_q) >= 10'sd255) begin
            sel_r     = {s1_raw_r_q[31], 8'hFF, 23'b0};
            sel_flags = FLAG_OF | FLAG_NX;
        end else if ($signed(s1_raw_exp_q) <= 10'sd0) begin
            sel_r     = {s1_raw_r_q[31], 31'b0};
            sel_flags = FLAG_UF | FLAG_NX;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_flags_d = out_flags_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_r_d     = sel_r;
                out_flags_d = sel_flags;
            end
        end
    end

    // A clear coinciding with a transfer keeps only the flags of that transfer.
    always_comb begin
        fflags_d = fflags_clr ? 5'b0 : fflags_q;
        if (out_xfer) begin
            fflags_d = fflags_d | out_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_x_q        <= 32'b0;
            s1_y_q        <= 32'b0;
            s1_raw_r_q    <= 32'b0;
            s1_raw_exp_q  <= 10'b0;
            s1_raw_zero_q <= 1'b0;
            s1_inexact_q  <= 1'b0;
            s1_cx_q       <= '0;
            s1_cy_q       <= '0;
            out_valid_q   <= 1'b0;
            out_r_q       <= 32'b0;
            out_flags_q   <= 5'b0;
            fflags_q      <= 5'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_raw_r_q    <= s1_raw_r_d;
            s1_raw_exp_q  <= s1_raw_exp_d;
            s1_raw_zero_q <= s1_raw_zero_d;
            s1_inexact_q  <= s1_inexact_d;
            s1_cx_q       <= s1_cx_d;
            s1_cy_q       <= s1_cy_d;
            out_valid_q   <= out_valid_d;
            out_r_q       <= out_r_d;
            out_flags_q   <= out_flags_d;
            fflags_q      <= fflags_d;
        end
    end

`ifdef FP32_ADD_POST_EXC_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = fflags_clr ? '0 : cnt_q;
        if (out_xfer && (|out_flags_q) && !(&cnt_d)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exc_count = cnt_q;
`endif

endmodule

// File: tb/tb_fp32_add_post.sv
// Directed bench for fp32_add_post: vector table, backpressure, sticky flags and async reset.
module tb_fp32_add_post;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y, in_raw_r;
  logic [9:0]  in_raw_exp;
  logic        in_raw_zero, in_inexact;
  logic        out_valid, out_ready;
  logic [31:0] out_r;
  logic [4:0]  out_flags, fflags;
  logic        fflags_clr;
`ifdef FP32_ADD_POST_EXC_CNT_EN
  logic [15:0] exc_count;
`endif

  fp32_add_post dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_raw_r   (in_raw_r),
    .in_raw_exp (in_raw_exp),
    .in_raw_zero(in_raw_zero),
    .in_inexact (in_inexact),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_flags  (out_flags),
    .fflags     (fflags),
`ifdef FP32_ADD_POST_EXC_CNT_EN
    .exc_count  (exc_count),
`endif
    .fflags_clr (fflags_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] raw_r;
    logic [9:0]  raw_exp;
    logic        raw_zero;
    logic        inexact;
    logic [31:0] exp_r;
    logic [4:0]  exp_f;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_ff = 5'b0;
  logic [36:0] exp_q[$];
  bit sb_on = 1'b0;
  int n_out = 0;

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] rr,
                              input logic [9:0] re, input logic rz, input logic nx,
                              input logic [31:0] er, input logic [4:0] ef);
    vec_t v;
    v.x = x; v.y = y; v.raw_r = rr; v.raw_exp = re; v.raw_zero = rz; v.inexact = nx;
    v.exp_r = er; v.exp_f = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    in_x = v.x; in_y = v.y; in_raw_r = v.raw_r; in_raw_exp = v.raw_exp;
    in_raw_zero = v.raw_zero; in_inexact = v.inexact;
  endtask

  task automatic run_vec(input vec_t v, input bit clr, input string tag);
    int n;
    @(posedge clk); #1;
    drive(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_early"}, 37'(out_valid), 37'd0);
    @(posedge clk); #1;
    fflags_clr = clr;
    @(negedge clk);
    chk({tag, "_valid"}, 37'(out_valid), 37'd1);
    chk({tag, "_r"}, 37'(out_r), 37'(v.exp_r));
    chk({tag, "_flags"}, 37'(out_flags), 37'(v.exp_f));
    exp_ff = (clr ? 5'b0 : exp_ff) | v.exp_f;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    chk({tag, "_fflags"}, 37'(fflags), 37'(exp_ff));
    chk({tag, "_drained"}, 37'(out_valid), 37'd0);
  endtask

  // scoreboard: compares every output transfer while enabled
  always @(negedge clk) begin
    if (sb_on && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 37'({out_flags, out_r}), 37'h0);
      end else begin
        chk($sformatf("sb_out%0d", n_out), {out_flags, out_r}, exp_q.pop_front());
        exp_ff = exp_ff | out_flags;
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_r;
    logic [4:0]  held_f;
    int n;

    vecs[0]  = mk(32'h3F800000, 32'h40000000, 32'h40400000, 10'd128,   0, 0, 32'h40400000, 5'h00);
    vecs[1]  = mk(32'h7F800001, 32'h3F800000, 32'h00000000, 10'd0,     0, 0, 32'h7FC00000, 5'h10);
    vecs[2]  = mk(32'h7F800000, 32'hFF800000, 32'h00000000, 10'd0,     0, 0, 32'h7FC00000, 5'h10);
    vecs[3]  = mk(32'hFF800000, 32'h3F800000, 32'h12345678, 10'd36,    0, 1, 32'hFF800000, 5'h00);
    vecs[4]  = mk(32'h3F800000, 32'h3F800000, 32'h7F000000, 10'd255,   0, 0, 32'h7F800000, 5'h05);
    vecs[5]  = mk(32'hBF800000, 32'hBF7FFFFF, 32'h80800000, 10'h3FF,   0, 1, 32'h80000000, 5'h03);
    vecs[6]  = mk(32'h80000000, 32'h80000000, 32'h11111111, 10'd0,     0, 0, 32'h80000000, 5'h00);
    vecs[7]  = mk(32'h3F800000, 32'hBF800000, 32'h80000000, 10'd0,     1, 0, 32'h00000000, 5'h00);
    vecs[8]  = mk(32'h00000001, 32'hC0000000, 32'hC0000001, 10'd128,   0, 1, 32'hC0000000, 5'h00);
    vecs[9]  = mk(32'h3F800000, 32'h7FC00001, 32'h00000000, 10'd0,     0, 0, 32'h7FC00000, 5'h00);
    vecs[10] = mk(32'h7F800000, 32'h7F800000, 32'h00000000, 10'd0,     0, 0, 32'h7F800000, 5'h00);
    vecs[11] = mk(32'h00000000, 32'h80000000, 32'h80000000, 10'd0,     0, 0, 32'h00000000, 5'h00);
    vecs[12] = mk(32'h00000000, 32'h41200000, 32'h41200001, 10'd130,   0, 1, 32'h41200000, 5'h00);
    vecs[13] = mk(32'h3F800000, 32'h3F2AAAAB, 32'h3FAAAAAB, 10'd127,   0, 1, 32'h3FAAAAAB, 5'h01);
    vecs[14] = mk(32'h7F000000, 32'h7E800000, 32'h7F7FFFFF, 10'd254,   0, 1, 32'h7F7FFFFF, 5'h01);
    vecs[15] = mk(32'h01000000, 32'h80800000, 32'h00800000, 10'd1,     0, 0, 32'h00800000, 5'h00);
    vecs[16] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 10'h1FF,   0, 0, 32'h7F800000, 5'h05);
    vecs[17] = mk(32'hBF800000, 32'hBF800000, 32'hBF800000, 10'h200,   0, 0, 32'h80000000, 5'h03);
    vecs[18] = mk(32'h7FC00000, 32'hFF800000, 32'h00000000, 10'd0,     0, 0, 32'h7FC00000, 5'h00);
    vecs[19] = mk(32'hFF800000, 32'h7FA00000, 32'h00000000, 10'd0,     0, 0, 32'h7FC00000, 5'h10);
    vecs[20] = mk(32'h00000001, 32'h80000002, 32'h80000001, 10'd0,     0, 0, 32'h00000000, 5'h00);
    vecs[21] = mk(32'h00800000, 32'h80C00000, 32'h80400000, 10'd0,     0, 1, 32'h80000000, 5'h03);
    vecs[22] = mk(32'h7F800001, 32'h7F800000, 32'h7F800000, 10'd255,   0, 1, 32'h7FC00000, 5'h10);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    fflags_clr = 1'b0;
    drive(vecs[0]);
    #3;
    chk("rst_out_valid", 37'(out_valid), 37'd0);
    chk("rst_out_r", 37'(out_r), 37'd0);
    chk("rst_out_flags", 37'(out_flags), 37'd0);
    chk("rst_fflags", 37'(fflags), 37'd0);
    chk("rst_in_ready", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));
    end
    chk("table_fflags_all", 37'(fflags), 37'h17);

    // backpressure: out_ready low for three cycles while four inputs stream in
    sb_on = 1'b1;
    n_out = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready0", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    exp_q.push_back({vecs[0].exp_f, vecs[0].exp_r});
    drive(vecs[13]);
    @(negedge clk);
    chk("bp_ready1", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    exp_q.push_back({vecs[13].exp_f, vecs[13].exp_r});
    drive(vecs[4]);
    @(negedge clk);
    chk("bp_ready_drop", 37'(in_ready), 37'd0);
    chk("bp_out_valid", 37'(out_valid), 37'd1);
    held_r = out_r;
    held_f = out_flags;
    chk("bp_first_r", 37'(out_r), 37'(vecs[0].exp_r));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold_r", 37'(out_r), 37'(held_r));
    chk("bp_hold_flags", 37'(out_flags), 37'(held_f));
    chk("bp_ready_still_low", 37'(in_ready), 37'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    exp_q.push_back({vecs[4].exp_f, vecs[4].exp_r});
    drive(vecs[5]);
    @(negedge clk);
    chk("bp_ready3", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    exp_q.push_back({vecs[5].exp_f, vecs[5].exp_r});
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_queue_drained", 37'(exp_q.size()), 37'd0);
    chk("bp_out_count", 37'(n_out), 37'd4);
    chk("bp_fflags", 37'(fflags), 37'(exp_ff));
    sb_on = 1'b0;

    // sticky flags: overflow accumulates, then clear coinciding with an NX-only transfer
    run_vec(vecs[4], 1'b0, "sticky_of");
    chk("sticky_of_bits", 37'(fflags & 5'h05), 37'h05);
    run_vec(vecs[13], 1'b1, "sticky_clr_nx");
    chk("sticky_nx_only", 37'(fflags), 37'h01);

    // asynchronous reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(vecs[4]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 37'(out_valid), 37'd1);
    chk("mid_in_ready", 37'(in_ready), 37'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 37'(out_valid), 37'd0);
    chk("arst_fflags", 37'(fflags), 37'd0);
    chk("arst_out_r", 37'(out_r), 37'd0);
    chk("arst_in_ready", 37'(in_ready), 37'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", k), 37'(out_valid), 37'd0);
    end
    chk("post_rst_fflags", 37'(fflags), 37'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
